// File: rtl/trg_ack_pkg.sv
// Shared encodings for the trigger/acknowledge sequencer.
package trg_ack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic MODE_PULSE = 1'b0;
   localparam logic MODE_LEVEL = 1'b1;

endpackage

// File: rtl/ack_sync_edge.sv
// Per-bit two-flop synchroniser for the asynchronous ACK lines, followed by
// a rising-edge detector on the synchronised value.
module ack_sync_edge #(
   parameter int N_CH = 12
) (
   input  logic            BOARD_CLOCK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] ACK_I,
   output logic [N_CH-1:0] ACK_RISE_O
);

   logic [N_CH-1:0] ack_p0, ack_p1, ack_p2;

   always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         ack_p0 <= '0;
         ack_p1 <= '0;
         ack_p2 <= '0;
      end else begin
         ack_p0 <= ACK_I;
         ack_p1 <= ack_p0;
         ack_p2 <= ack_p1;
      end
   end

   // ack_p2 only remembers the previous synchronised value for edge detection
   assign ACK_RISE_O = ack_p1 & ~ack_p2;

endmodule

// File: rtl/trg_ack_ctrl.sv
// Trigger/acknowledge sequencer: fires masked TRG lines (pulse or level),
// collects ACK rising edges and finishes on all-acked, timeout or abort.
module trg_ack_ctrl
   import trg_ack_pkg::*;
#(
   parameter int N_CH    = 12,
   parameter int PULSE_W = 4,
   parameter int TMO_W   = 16
) (
   input  logic             BOARD_CLOCK,
   input  logic             RST_N,
   input  logic             TRG_START_I,
   input  logic             ABORT_I,
   input  logic             MODE_I,
   input  logic [N_CH-1:0]  TRG_MASK_I,
   input  logic [TMO_W-1:0] TMO_LIMIT_I,
   input  logic [N_CH-1:0]  ACK_I,
   output logic [N_CH-1:0]  TRG_O,
   output logic             BUSY_O,
   output logic             DONE_O,
   output logic [N_CH-1:0]  ACK_SEEN_O,
   output logic             TMO_O
);

   localparam int                PCNT_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);

   state_e            state_q, state_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic              mode_q, mode_d;
   logic [TMO_W-1:0]  limit_q, limit_d;
   logic [TMO_W-1:0]  timer_q, timer_d, timer_inc;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [N_CH-1:0]   ack_rise, seen_acc, seen_d, trg_d;
   logic              all_seen, tmo_hit, tmo_d;

   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      return (&v) ? v : v + TMO_W'(1);
   endfunction

   ack_sync_edge #(.N_CH(N_CH)) u_ack_sync_edge (
      .BOARD_CLOCK (BOARD_CLOCK),
      .RST_N       (RST_N),
      .ACK_I       (ACK_I),
      .ACK_RISE_O  (ack_rise)
   );

   assign seen_acc  = ACK_SEEN_O | (ack_rise & mask_q);
   assign all_seen  = (seen_acc == mask_q);
   assign timer_inc = sat_inc(timer_q);
   // >= rather than == so a limit shorter than the pulse still ends the sequence
   assign tmo_hit   = (limit_q != '0) && (timer_inc >= limit_q);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      mode_d  = mode_q;
      limit_d = limit_q;
      timer_d = timer_q;
      pcnt_d  = pcnt_q;
      seen_d  = ACK_SEEN_O;
      tmo_d   = TMO_O;
      trg_d   = '0;
      case (state_q)
         IDLE: begin
            if (TRG_START_I) begin
               mask_d  = TRG_MASK_I;
               mode_d  = MODE_I;
               limit_d = TMO_LIMIT_I;
               timer_d = '0;
               pcnt_d  = '0;
               seen_d  = '0;
               tmo_d   = 1'b0;
               if (TRG_MASK_I == '0)        state_d = DONE;
               else if (MODE_I == MODE_PULSE) state_d = FIRE;
               else                         state_d = WAIT;
            end
         end
         FIRE: begin
            timer_d = timer_inc;
            seen_d  = seen_acc;
            if (ABORT_I) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end else begin
               trg_d = mask_q;
               if (pcnt_q == PCNT_LAST) begin
                  if (all_seen) begin
                     state_d = DONE;
                  end else if (tmo_hit) begin
                     tmo_d   = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = WAIT;
                  end
               end else begin
                  pcnt_d = pcnt_q + PCNT_W'(1);
               end
            end
         end
         WAIT: begin
            timer_d = timer_inc;
            seen_d  = seen_acc;
            if (ABORT_I) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end else if (all_seen) begin
               state_d = DONE;
            end else if (tmo_hit) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end else if (mode_q == MODE_LEVEL) begin
               trg_d = mask_q & ~seen_acc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         mode_q     <= 1'b0;
         limit_q    <= '0;
         timer_q    <= '0;
         pcnt_q     <= '0;
         TRG_O      <= '0;
         BUSY_O     <= 1'b0;
         DONE_O     <= 1'b0;
         ACK_SEEN_O <= '0;
         TMO_O      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         limit_q    <= limit_d;
         timer_q    <= timer_d;
         pcnt_q     <= pcnt_d;
         TRG_O      <= trg_d;
         BUSY_O     <= (state_q == FIRE) || (state_q == WAIT);
         DONE_O     <= (state_q == DONE);
         ACK_SEEN_O <= seen_d;
         TMO_O      <= tmo_d;
      end
   end

endmodule

// File: tb/tb_trg_ack_ctrl.sv
// Bench for trg_ack_ctrl: directed scenarios plus randomized sequences checked
// against an event-time model of each sequence.
module tb_trg_ack_ctrl;
   import trg_ack_pkg::*;

   localparam int N_CH    = 12;
   localparam int PULSE_W = 4;
   localparam int TMO_W   = 16;
   localparam int MAXE    = 128;
   localparam int PRE     = 5;
   localparam int INF     = 1 << 30;

   logic             BOARD_CLOCK = 1'b0;
   logic             RST_N       = 1'b0;
   logic             TRG_START_I = 1'b0;
   logic             ABORT_I     = 1'b0;
   logic             MODE_I      = 1'b0;
   logic [N_CH-1:0]  TRG_MASK_I  = '0;
   logic [TMO_W-1:0] TMO_LIMIT_I = '0;
   logic [N_CH-1:0]  ACK_I       = '0;
   logic [N_CH-1:0]  TRG_O;
   logic             BUSY_O;
   logic             DONE_O;
   logic [N_CH-1:0]  ACK_SEEN_O;
   logic             TMO_O;

   int n_chk = 0;
   int n_err = 0;

   logic [N_CH-1:0] wave [MAXE];
   int abort_at;
   int stray_at;

   trg_ack_ctrl #(.N_CH(N_CH), .PULSE_W(PULSE_W), .TMO_W(TMO_W)) dut (
      .BOARD_CLOCK (BOARD_CLOCK),
      .RST_N       (RST_N),
      .TRG_START_I (TRG_START_I),
      .ABORT_I     (ABORT_I),
      .MODE_I      (MODE_I),
      .TRG_MASK_I  (TRG_MASK_I),
      .TMO_LIMIT_I (TMO_LIMIT_I),
      .ACK_I       (ACK_I),
      .TRG_O       (TRG_O),
      .BUSY_O      (BUSY_O),
      .DONE_O      (DONE_O),
      .ACK_SEEN_O  (ACK_SEEN_O),
      .TMO_O       (TMO_O)
   );

   always #5 BOARD_CLOCK = ~BOARD_CLOCK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [N_CH-1:0] trg, input logic busy,
                                input logic done, input logic [N_CH-1:0] seen, input logic tmo);
      check({tag, ".trg"},  32'(TRG_O),      32'(trg));
      check({tag, ".busy"}, 32'(BUSY_O),     32'(busy));
      check({tag, ".done"}, 32'(DONE_O),     32'(done));
      check({tag, ".seen"}, 32'(ACK_SEEN_O), 32'(seen));
      check({tag, ".tmo"},  32'(TMO_O),      32'(tmo));
   endtask

   task automatic clear_wave(input logic [N_CH-1:0] base);
      for (int e = 0; e < MAXE; e++) wave[e] = base;
   endtask

   task automatic rise_at(input int ch, input int k);
      for (int e = k; e < MAXE; e++) wave[e][ch] = 1'b1;
   endtask

   // Model: each ACK edge sampled at edge k is seen at edge k+2; the sequence
   // ends (enters DONE) at the earliest of abort, all-seen and timeout, with
   // all-seen/timeout not earlier than the end of the fire phase.
   task automatic run_seq(input string name, input logic [N_CH-1:0] mask, input logic mode,
                          input logic [TMO_W-1:0] limit);
      int jrise [N_CH];
      int j_all, fire_len, t_ack, t_tmo, t_abt, t_end;
      bit by_abort, tmo_flag;
      logic [N_CH-1:0] seen, exp_trg;

      for (int ch = 0; ch < N_CH; ch++) begin
         jrise[ch] = INF;
         for (int e = 1; e < MAXE; e++)
            if (jrise[ch] == INF && !wave[e-1][ch] && wave[e][ch]) jrise[ch] = e + 2;
      end
      j_all = 0;
      for (int ch = 0; ch < N_CH; ch++)
         if (mask[ch] && jrise[ch] > j_all) j_all = jrise[ch];
      fire_len = (mode == MODE_PULSE) ? PULSE_W : 1;

      if (mask == '0) begin
         t_end    = 0;
         tmo_flag = 1'b0;
         by_abort = 1'b0;
      end else begin
         t_ack = (j_all >= INF) ? INF : ((j_all > fire_len) ? j_all : fire_len);
         t_tmo = (limit == '0) ? INF : ((int'(limit) > fire_len) ? int'(limit) : fire_len);
         t_abt = (abort_at >= 1) ? abort_at : INF;
         t_end = t_abt;
         if (t_ack < t_end) t_end = t_ack;
         if (t_tmo < t_end) t_end = t_tmo;
         by_abort = (t_abt == t_end);
         tmo_flag = by_abort || (t_ack != t_end);
      end

      repeat (PRE) begin
         @(negedge BOARD_CLOCK);
         ACK_I       = wave[0];
         TRG_START_I = 1'b0;
         ABORT_I     = 1'b0;
      end

      for (int e = 0; e <= t_end + 3; e++) begin
         @(negedge BOARD_CLOCK);
         ACK_I       = wave[e];
         TRG_START_I = (e == 0) || (e == stray_at);
         ABORT_I     = (e == abort_at);
         if (e == 0) begin
            MODE_I      = mode;
            TRG_MASK_I  = mask;
            TMO_LIMIT_I = limit;
         end else begin
            MODE_I      = 1'($urandom);
            TRG_MASK_I  = N_CH'($urandom);
            TMO_LIMIT_I = TMO_W'($urandom);
         end
         @(posedge BOARD_CLOCK);
         #1;
         seen = '0;
         for (int ch = 0; ch < N_CH; ch++)
            if (mask[ch] && jrise[ch] <= e && jrise[ch] <= t_end) seen[ch] = 1'b1;
         if (mode == MODE_PULSE)
            exp_trg = (e >= 1 && e <= PULSE_W && (e < t_end || (e == t_end && !by_abort))) ? mask : '0;
         else
            exp_trg = (e >= 1 && e < t_end) ? (mask & ~seen) : '0;
         check_outputs($sformatf("%s@%0d", name, e), exp_trg, (e >= 1 && e <= t_end),
                       (e == t_end + 1), seen, (e >= t_end) ? tmo_flag : 1'b0);
      end
   endtask

   initial begin
      logic [N_CH-1:0] mask;
      logic            mode;
      logic [TMO_W-1:0] limit;
      logic [N_CH-1:0] w;
      int              ch, off;

      repeat (3) @(posedge BOARD_CLOCK);
      #1;
      check_outputs("reset", '0, 1'b0, 1'b0, '0, 1'b0);
      @(negedge BOARD_CLOCK);
      RST_N = 1'b1;

      // Pulse, two channels acked together
      clear_wave('0); rise_at(0, 10); rise_at(2, 10);
      abort_at = -1; stray_at = -1;
      run_seq("pulse_ok", 12'h005, MODE_PULSE, '0);

      // Pulse, one of two channels acked, timeout at 20
      clear_wave('0); rise_at(0, 5);
      run_seq("pulse_tmo", 12'h003, MODE_PULSE, 16'd20);

      // Level, staggered acks drop TRG bits one by one
      clear_wave('0); rise_at(0, 5); rise_at(1, 8); rise_at(2, 11); rise_at(3, 14);
      run_seq("level_ok", 12'h00F, MODE_LEVEL, '0);

      // ACK5 held high before start, ACK7 unmasked rising
      clear_wave(12'h020); rise_at(7, 10);
      run_seq("pre_high", 12'h020, MODE_PULSE, 16'd30);

      // Abort in WAIT with a stray start while busy
      clear_wave('0);
      abort_at = 6; stray_at = 3;
      run_seq("abort", 12'h003, MODE_LEVEL, '0);

      // Asynchronous reset in the middle of a level sequence
      @(negedge BOARD_CLOCK);
      TRG_START_I = 1'b1; TRG_MASK_I = 12'h00F; MODE_I = MODE_LEVEL;
      TMO_LIMIT_I = '0; ACK_I = '0; ABORT_I = 1'b0;
      @(negedge BOARD_CLOCK);
      TRG_START_I = 1'b0;
      repeat (7) @(posedge BOARD_CLOCK);
      #2;
      check("pre_rst.trg",  32'(TRG_O),  32'(12'h00F));
      check("pre_rst.busy", 32'(BUSY_O), 32'(1'b1));
      RST_N = 1'b0;
      #1;
      check_outputs("mid_rst", '0, 1'b0, 1'b0, '0, 1'b0);
      repeat (2) @(negedge BOARD_CLOCK);
      RST_N = 1'b1;
      clear_wave('0);
      abort_at = -1; stray_at = -1;
      run_seq("zero_mask", '0, MODE_PULSE, 16'd7);

      for (int s = 0; s < 40; s++) begin
         case ($urandom % 8)
            0:       mask = '0;
            1, 2:    mask = N_CH'(1) << ($urandom % N_CH);
            default: mask = (N_CH'(1) << ($urandom % N_CH)) | (N_CH'(1) << ($urandom % N_CH))
                            | (($urandom % 2 == 0) ? (N_CH'(1) << ($urandom % N_CH)) : '0);
         endcase
         mode = 1'($urandom);
         case ($urandom % 4)
            0:       limit = '0;
            1:       limit = TMO_W'($urandom_range(1, PULSE_W + 1));
            default: limit = TMO_W'($urandom_range(PULSE_W + 2, 50));
         endcase
         abort_at = (limit == '0 || $urandom % 5 == 0) ? int'($urandom_range(1, 55)) : -1;
         stray_at = (mask == '0) ? -1 : int'($urandom_range(1, 2));
         wave[0] = N_CH'($urandom);
         for (int e = 1; e < MAXE; e++) begin
            w = wave[e-1];
            if ($urandom % 3 == 0) begin
               ch = $urandom % N_CH;
               if (mask != '0 && $urandom % 10 < 7) begin
                  off = ch;
                  for (int i = N_CH - 1; i >= 0; i--)
                     if (mask[(off + i) % N_CH]) ch = (off + i) % N_CH;
               end
               w[ch] = ~w[ch];
            end
            wave[e] = w;
         end
         run_seq($sformatf("rnd%0d", s), mask, mode, limit);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
